// File: rtl/fast_square_tx.sv
//============================================================================
// Module      : fast_square_tx
// Description : Fast-square multi-subcarrier transmitter. Synthesises four
//               quadrature square-wave subcarriers at carrier + {-3f,-f,+f,+3f},
//               steps the subcarrier offsets once per dwell and emits the
//               dwell timing (freq_step / tx_active / sweep_done) that keeps
//               the matching receiver frequency-locked.
// Ports       : clock, reset (sync, active-high), enable (sweep level),
//               sample_strobe (one per output sample), serial_addr/data/
//               strobe (settings bus), i_out/q_out (signed 16-bit samples),
//               freq_step (end-of-dwell pulse), tx_active (dwell in
//               progress), sweep_done (pulse after the final dwell).
// Options     : `define FAST_SQUARE_TX_CONT_EN for continuous sweeping;
//               undefined gives a one-shot sweep per enable rising level.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

// Single settings-bus register: captures data when its address is written.
module setting_reg #(
    parameter int MY_ADDR = 0,
    parameter int WIDTH   = 32
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             strobe,
    input  logic [6:0]       addr,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out
);
    logic [WIDTH-1:0] data_q, data_d;

    always_comb begin
        data_d = data_q;
        if (strobe && (addr == 7'(MY_ADDR)))
            data_d = data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign data_out = data_q;
endmodule

module fast_square_tx #(
    parameter int CARRIERFREQADDR    = 0,
    parameter int SUBCARRIERFREQADDR = 1,
    parameter int AMPLADDR           = 3,
    parameter int DWELL_TICKS_LOG2   = 14,
    parameter int GAP_TICKS          = 64,
    parameter int NUM_STEPS          = 16
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        enable,
    input  logic        sample_strobe,
    input  logic [6:0]  serial_addr,
    input  logic [31:0] serial_data,
    input  logic        serial_strobe,
    output logic [15:0] i_out,
    output logic [15:0] q_out,
    output logic        freq_step,
    output logic        tx_active,
    output logic        sweep_done
);
    localparam int GAP_W  = (GAP_TICKS > 1) ? $clog2(GAP_TICKS) : 1;
    localparam int STEP_W = (NUM_STEPS > 1) ? $clog2(NUM_STEPS) : 1;
    localparam logic [DWELL_TICKS_LOG2-1:0] C_DWELL_LAST = '1;
    localparam logic [GAP_W-1:0]  C_GAP_LAST  = GAP_W'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);
    localparam logic [STEP_W-1:0] C_STEP_LAST = STEP_W'(NUM_STEPS - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_TX   = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    // A zero gap restarts the next dwell directly from TX.
    localparam state_t C_AFTER_DWELL = (GAP_TICKS == 0) ? ST_TX : ST_GAP;

    // Settings bus registers (never reset, so settings survive a sweep reset)
    logic [31:0] w_carrier, w_sub;
    logic [15:0] w_ampl;

    setting_reg #(.MY_ADDR(CARRIERFREQADDR), .WIDTH(32)) u_sr_carrier (
        .clock(clock), .reset(1'b0), .strobe(serial_strobe), .addr(serial_addr),
        .data_in(serial_data), .data_out(w_carrier));
    setting_reg #(.MY_ADDR(SUBCARRIERFREQADDR), .WIDTH(32)) u_sr_sub (
        .clock(clock), .reset(1'b0), .strobe(serial_strobe), .addr(serial_addr),
        .data_in(serial_data), .data_out(w_sub));
    setting_reg #(.MY_ADDR(AMPLADDR), .WIDTH(16)) u_sr_ampl (
        .clock(clock), .reset(1'b0), .strobe(serial_strobe), .addr(serial_addr),
        .data_in(serial_data[15:0]), .data_out(w_ampl));

    // Registers
    state_t                      state_q, state_d;
    logic                        armed_q, armed_d;
    logic [DWELL_TICKS_LOG2-1:0] dwell_q, dwell_d;
    logic [GAP_W-1:0]            gap_q, gap_d;
    logic [STEP_W-1:0]           step_q, step_d;
    logic [31:0]                 ph_q [4], ph_d [4];
    logic [31:0]                 tf_q [4], tf_d [4];
    logic [31:0]                 cf_q, cf_d;
    logic [31:0]                 step_small_q, step_small_d;
    logic [31:0]                 step_large_q, step_large_d;
    logic [15:0]                 a_q, a_d;
    logic [15:0]                 iout_q, iout_d;
    logic [15:0]                 qout_q, qout_d;
    logic                        freq_step_q, freq_step_d;
    logic                        sweep_done_q, sweep_done_d;

    // Datapath helpers
    logic [31:0] w_f3;
    logic [15:0] w_neg_a;
    logic        w_take_large;
    logic [15:0] w_sum_i, w_sum_q;
    logic [31:0] w_ph_next [4];
    logic [31:0] w_tf_step [4];
    logic        w_latch;

    assign w_f3    = w_sub + (w_sub << 1);
    assign w_neg_a = 16'd0 - a_q;
    // Step decision uses the pre-step -f lane, shared by all four lanes.
    assign w_take_large = $signed(tf_q[1]) > $signed(32'd0 - step_small_q);

    always_comb begin
        w_sum_i = '0;
        w_sum_q = '0;
        for (int k = 0; k < 4; k++) begin
            // Quadrant of the phase picks the sign: I flips at 90/270 deg,
            // Q flips at 180 deg.
            w_sum_i = w_sum_i + ((ph_q[k][31] ^ ph_q[k][30]) ? w_neg_a : a_q);
            w_sum_q = w_sum_q + (ph_q[k][31] ? w_neg_a : a_q);
            w_ph_next[k] = ph_q[k] + cf_q + tf_q[k];
            w_tf_step[k] = tf_q[k] + (w_take_large ? step_large_q : step_small_q);
        end
    end

    always_comb begin
        state_d      = state_q;
        armed_d      = armed_q;
        dwell_d      = dwell_q;
        gap_d        = gap_q;
        step_d       = step_q;
        ph_d         = ph_q;
        tf_d         = tf_q;
        cf_d         = cf_q;
        step_small_d = step_small_q;
        step_large_d = step_large_q;
        a_d          = a_q;
        iout_d       = iout_q;
        qout_d       = qout_q;
        freq_step_d  = 1'b0;
        sweep_done_d = 1'b0;
        w_latch      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                iout_d = '0;
                qout_d = '0;
                if (!enable) begin
                    armed_d = 1'b1;
                end else if (armed_q) begin
                    state_d = ST_TX;
                    w_latch = 1'b1;
                end
            end
            ST_TX: begin
                if (!enable) begin
                    state_d = ST_IDLE;
                    iout_d  = '0;
                    qout_d  = '0;
                end else if (sample_strobe) begin
                    iout_d  = w_sum_i;
                    qout_d  = w_sum_q;
                    ph_d    = w_ph_next;
                    dwell_d = dwell_q + DWELL_TICKS_LOG2'(1);
                    if (dwell_q == C_DWELL_LAST) begin
                        freq_step_d = 1'b1;
                        dwell_d     = '0;
                        gap_d       = '0;
                        tf_d        = w_tf_step;
                        for (int k = 0; k < 4; k++) ph_d[k] = '0;
                        if (step_q == C_STEP_LAST) begin
                            sweep_done_d = 1'b1;
                            step_d       = '0;
`ifdef FAST_SQUARE_TX_CONT_EN
                            w_latch = 1'b1;
                            state_d = C_AFTER_DWELL;
`else
                            // One-shot: wait for enable to drop before rearming.
                            armed_d = 1'b0;
                            state_d = ST_IDLE;
`endif
                        end else begin
                            step_d  = step_q + STEP_W'(1);
                            state_d = C_AFTER_DWELL;
                        end
                    end
                end
            end
            ST_GAP: begin
                iout_d = '0;
                qout_d = '0;
                if (!enable) begin
                    state_d = ST_IDLE;
                end else if (sample_strobe) begin
                    gap_d = gap_q + GAP_W'(1);
                    if (gap_q == C_GAP_LAST) begin
                        gap_d   = '0;
                        state_d = ST_TX;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Settings snapshot at sweep start; counters and phases restart too.
        if (w_latch) begin
            cf_d         = w_carrier;
            tf_d[0]      = 32'd0 - w_f3;
            tf_d[1]      = 32'd0 - w_sub;
            tf_d[2]      = w_sub;
            tf_d[3]      = w_f3;
            step_small_d = 32'h8000_0000 - (w_f3 << 1);
            step_large_d = 32'h8000_0000 - (w_sub << 3);
            a_d          = 16'($signed(w_ampl) >>> 2);
            dwell_d      = '0;
            gap_d        = '0;
            step_d       = '0;
            for (int k = 0; k < 4; k++) ph_d[k] = '0;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            armed_q      <= 1'b1;
            dwell_q      <= '0;
            gap_q        <= '0;
            step_q       <= '0;
            for (int k = 0; k < 4; k++) begin
                ph_q[k] <= '0;
                tf_q[k] <= '0;
            end
            cf_q         <= '0;
            step_small_q <= '0;
            step_large_q <= '0;
            a_q          <= '0;
            iout_q       <= '0;
            qout_q       <= '0;
            freq_step_q  <= 1'b0;
            sweep_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            armed_q      <= armed_d;
            dwell_q      <= dwell_d;
            gap_q        <= gap_d;
            step_q       <= step_d;
            ph_q         <= ph_d;
            tf_q         <= tf_d;
            cf_q         <= cf_d;
            step_small_q <= step_small_d;
            step_large_q <= step_large_d;
            a_q          <= a_d;
            iout_q       <= iout_d;
            qout_q       <= qout_d;
            freq_step_q  <= freq_step_d;
            sweep_done_q <= sweep_done_d;
        end
    end

    assign i_out      = iout_q;
    assign q_out      = qout_q;
    assign freq_step  = freq_step_q;
    assign sweep_done = sweep_done_q;
    assign tx_active  = (state_q == ST_TX);

endmodule

`default_nettype wire

// File: tb/tb_fast_square_tx.sv
//============================================================================
// Module      : tb_fast_square_tx
// Description : Self-checking bench for fast_square_tx. A default-parameter
//               instance checks the long first dwell; a small instance
//               (16-strobe dwells, 3-strobe gaps, 2 steps) is checked
//               cycle by cycle against a scoreboard of expected rows.
// Revision    : 1.0 - initial release
//============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_fast_square_tx;
    localparam int SM_L2    = 4;
    localparam int SM_GAP   = 3;
    localparam int SM_STEPS = 2;
    localparam int SM_N     = 1 << SM_L2;
    localparam int BIG_N    = 1 << 14;
`ifdef FAST_SQUARE_TX_CONT_EN
    localparam int EXTRA_DWELLS = 1;
`else
    localparam int EXTRA_DWELLS = 0;
`endif

    logic        clock = 1'b0;
    logic        reset;
    logic        enable_big, enable_sm;
    logic        sample_strobe;
    logic [6:0]  serial_addr;
    logic [31:0] serial_data;
    logic        serial_strobe;

    logic [15:0] big_i, big_q, sm_i, sm_q;
    logic        big_fs, big_ta, big_sd, sm_fs, sm_ta, sm_sd;

    always #5 clock = ~clock;

    fast_square_tx u_big (
        .clock(clock), .reset(reset), .enable(enable_big), .sample_strobe(sample_strobe),
        .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
        .i_out(big_i), .q_out(big_q), .freq_step(big_fs), .tx_active(big_ta),
        .sweep_done(big_sd));

    fast_square_tx #(.DWELL_TICKS_LOG2(SM_L2), .GAP_TICKS(SM_GAP), .NUM_STEPS(SM_STEPS)) u_sm (
        .clock(clock), .reset(reset), .enable(enable_sm), .sample_strobe(sample_strobe),
        .serial_addr(serial_addr), .serial_data(serial_data), .serial_strobe(serial_strobe),
        .i_out(sm_i), .q_out(sm_q), .freq_step(sm_fs), .tx_active(sm_ta),
        .sweep_done(sm_sd));

    int n_checks = 0;
    int n_errors = 0;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    typedef struct packed {
        logic [15:0] i;
        logic [15:0] q;
        logic        fs;
        logic        ta;
        logic        sd;
    } exp_t;

    exp_t sb[$];

    task automatic write_setting(input logic [6:0] addr, input logic [31:0] data);
        serial_addr   = addr;
        serial_data   = data;
        serial_strobe = 1'b1;
        @(posedge clock); #1;
        serial_strobe = 1'b0;
    endtask

    // Expected per-clock rows for a sweep on the small instance with a strobe
    // every clock, starting from the clock on which enable is first sampled.
    // Sample n of a dwell has lane phase n*(cf+tf[k]).
    task automatic push_sweep(input logic [31:0] cf, input logic [31:0] f,
                              input logic [15:0] amp, input int ndw);
        logic [31:0] tf [4];
        logic [31:0] ss, sl, ph;
        logic [15:0] a, si, sq;
        exp_t        e;
        a  = 16'($signed(amp) >>> 2);
        ss = 32'h8000_0000 - 32'd6 * f;
        sl = 32'h8000_0000 - 32'd8 * f;
        for (int d = 0; d < ndw; d++) begin
            if (d % SM_STEPS == 0) begin
                tf[0] = 32'd0 - 32'd3 * f;
                tf[1] = 32'd0 - f;
                tf[2] = f;
                tf[3] = 32'd3 * f;
            end
            for (int j = 0; j < SM_N + SM_GAP; j++) begin
                si = '0;
                sq = '0;
                if (j >= 1 && j <= SM_N) begin
                    for (int k = 0; k < 4; k++) begin
                        ph = (cf + tf[k]) * 32'(j - 1);
                        si = si + (((ph[31] ^ ph[30]) != 1'b0) ? 16'd0 - a : a);
                        sq = sq + (ph[31] ? 16'd0 - a : a);
                    end
                end
                e.i  = si;
                e.q  = sq;
                e.ta = (j < SM_N);
                e.fs = (j == SM_N);
                e.sd = (j == SM_N) && (d % SM_STEPS == SM_STEPS - 1);
                sb.push_back(e);
            end
            if ($signed(tf[1]) > $signed(32'd0 - ss))
                for (int k = 0; k < 4; k++) tf[k] = tf[k] + sl;
            else
                for (int k = 0; k < 4; k++) tf[k] = tf[k] + ss;
        end
    endtask

    task automatic push_idle(input int n);
        exp_t e;
        e = '0;
        for (int j = 0; j < n; j++) sb.push_back(e);
    endtask

    task automatic drain(input string tag);
        exp_t e;
        int   idx;
        idx = 0;
        while (sb.size() > 0) begin
            @(posedge clock); #1;
            e = sb.pop_front();
            check_val($sformatf("%s[%0d].i_out", tag, idx), 32'(sm_i), 32'(e.i));
            check_val($sformatf("%s[%0d].q_out", tag, idx), 32'(sm_q), 32'(e.q));
            check_val($sformatf("%s[%0d].freq_step", tag, idx), 32'(sm_fs), 32'(e.fs));
            check_val($sformatf("%s[%0d].tx_active", tag, idx), 32'(sm_ta), 32'(e.ta));
            check_val($sformatf("%s[%0d].sweep_done", tag, idx), 32'(sm_sd), 32'(e.sd));
            idx++;
        end
    endtask

    initial begin
        reset         = 1'b1;
        enable_big    = 1'b1;
        enable_sm     = 1'b1;
        sample_strobe = 1'b1;
        serial_addr   = '0;
        serial_data   = '0;
        serial_strobe = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        check_val("rst.big_i", 32'(big_i), 32'h0);
        check_val("rst.big_ta", 32'(big_ta), 32'h0);
        check_val("rst.sm_q", 32'(sm_q), 32'h0);
        check_val("rst.sm_fs", 32'(sm_fs), 32'h0);
        check_val("rst.sm_sd", 32'(sm_sd), 32'h0);
        enable_big = 1'b0;
        enable_sm  = 1'b0;
        reset      = 1'b0;

        // Long default dwell: constant +4a output, first freq_step at 2^14.
        write_setting(7'd0, 32'h0);
        write_setting(7'd1, 32'h0);
        write_setting(7'd3, 32'h4000);
        enable_big = 1'b1;
        for (int j = 0; j <= BIG_N; j++) begin
            @(posedge clock); #1;
            if (j < BIG_N) check_val($sformatf("big[%0d].ta", j), 32'(big_ta), 32'h1);
            if (j >= 1) begin
                check_val($sformatf("big[%0d].i", j), 32'(big_i), 32'h4000);
                check_val($sformatf("big[%0d].q", j), 32'(big_q), 32'h4000);
            end
            check_val($sformatf("big[%0d].fs", j), 32'(big_fs), (j == BIG_N) ? 32'h1 : 32'h0);
            check_val($sformatf("big[%0d].sd", j), 32'(big_sd), 32'h0);
        end
        enable_big = 1'b0;
        @(posedge clock); #1;
        check_val("big.off.ta", 32'(big_ta), 32'h0);
        check_val("big.off.i", 32'(big_i), 32'h0);

        // Quarter-turn carrier, no subcarrier spacing.
        write_setting(7'd0, 32'h4000_0000);
        push_sweep(32'h4000_0000, 32'h0, 16'h4000, SM_STEPS + EXTRA_DWELLS);
        if (EXTRA_DWELLS == 0) push_idle(3);
        enable_sm = 1'b1;
        drain("carrier");
        enable_sm = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Subcarrier stepping with a smaller amplitude.
        write_setting(7'd0, 32'h0);
        write_setting(7'd1, 32'h0100_0000);
        write_setting(7'd3, 32'h2000);
        push_sweep(32'h0, 32'h0100_0000, 16'h2000, SM_STEPS + EXTRA_DWELLS);
        if (EXTRA_DWELLS == 0) push_idle(3);
        enable_sm = 1'b1;
        drain("stepping");
        enable_sm = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // Strobe gaps hold state; settings writes mid-sweep are deferred;
        // dropping enable returns to IDLE without a pulse.
        write_setting(7'd0, 32'h4000_0000);
        write_setting(7'd1, 32'h0);
        write_setting(7'd3, 32'h4000);
        enable_sm = 1'b1;
        @(posedge clock); #1;
        check_val("hold.ta", 32'(sm_ta), 32'h1);
        @(posedge clock); #1;
        check_val("hold.s0.i", 32'(sm_i), 32'h4000);
        @(posedge clock); #1;
        check_val("hold.s1.i", 32'(sm_i), 32'hC000);
        check_val("hold.s1.q", 32'(sm_q), 32'h4000);
        sample_strobe = 1'b0;
        write_setting(7'd0, 32'h0);
        check_val("hold.w.i", 32'(sm_i), 32'hC000);
        repeat (2) begin
            @(posedge clock); #1;
            check_val("hold.i", 32'(sm_i), 32'hC000);
            check_val("hold.q", 32'(sm_q), 32'h4000);
        end
        sample_strobe = 1'b1;
        @(posedge clock); #1;
        check_val("hold.s2.i", 32'(sm_i), 32'hC000);
        check_val("hold.s2.q", 32'(sm_q), 32'hC000);
        enable_sm = 1'b0;
        @(posedge clock); #1;
        check_val("drop.ta", 32'(sm_ta), 32'h0);
        check_val("drop.i", 32'(sm_i), 32'h0);
        check_val("drop.q", 32'(sm_q), 32'h0);
        check_val("drop.fs", 32'(sm_fs), 32'h0);
        check_val("drop.sd", 32'(sm_sd), 32'h0);

        // Reset mid-sweep, then restart with enable still high.
        @(posedge clock); #1;
        enable_sm = 1'b1;
        repeat (5) @(posedge clock);
        #1;
        check_val("mid.i", 32'(sm_i), 32'h4000);
        reset = 1'b1;
        @(posedge clock); #1;
        check_val("midrst.ta", 32'(sm_ta), 32'h0);
        check_val("midrst.i", 32'(sm_i), 32'h0);
        check_val("midrst.fs", 32'(sm_fs), 32'h0);
        reset = 1'b0;
        @(posedge clock); #1;
        check_val("restart.ta", 32'(sm_ta), 32'h1);
        @(posedge clock); #1;
        check_val("restart.i", 32'(sm_i), 32'h4000);
        enable_sm = 1'b0;
        @(posedge clock); #1;

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule

`default_nettype wire
